// File: rtl/grid_generation_memory.sv
// Ping-pong row memory for the Life engine: current/next generation banks, swap handshake and
// generation counter. Define STABLE_DETECT_EN to build the still-life detector; otherwise stable=0.
module grid_generation_memory #(
  parameter int unsigned COLS   = 16,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int unsigned GEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_run,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [COLS-1:0]   init_row,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COLS-1:0]   rd_row,
  input  logic              grid_we,
  input  logic [ADDR_W-1:0] grid_addr,
  input  logic [COLS-1:0]   grid_row,
  input  logic              gen_done,
  output logic              swap_ack,
  output logic [GEN_W-1:0]  gen_count,
  output logic              stable
);

  typedef enum logic [1:0] {StLoad, StRun, StSwap} state_e;

  localparam logic [ADDR_W:0] RowsLim = (ADDR_W + 1)'(ROWS);

  // Guards addresses beyond ROWS when ROWS is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < RowsLim;
  endfunction

  state_e              state_q, state_d;
  logic                cur_sel_q;
  logic [COLS-1:0]     bank_q [2][ROWS];
  logic [COLS-1:0]     rd_row_q;
  logic                swap_ack_q;
  logic [GEN_W-1:0]    gen_count_q;
  logic                init_wr, grid_wr, start_run;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad: if (load_run) state_d = StRun;
      StRun: begin
        if (!load_run)     state_d = StLoad;
        else if (gen_done) state_d = StSwap;
      end
      StSwap:  state_d = load_run ? StRun : StLoad;
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    init_wr   = (state_q == StLoad) && init_we && in_range(init_addr);
    grid_wr   = (state_q == StRun) && grid_we && in_range(grid_addr);
    start_run = (state_q == StLoad) && load_run;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          bank_q[b][r] <= '0;
        end
      end
      rd_row_q <= '0;
    end else begin
      // Nonblocking update gives read-before-write on a same-address collision.
      rd_row_q <= in_range(rd_addr) ? bank_q[cur_sel_q][rd_addr] : '0;
      if (init_wr) bank_q[cur_sel_q][init_addr] <= init_row;
      if (grid_wr) bank_q[~cur_sel_q][grid_addr] <= grid_row;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StLoad;
      cur_sel_q   <= 1'b0;
      swap_ack_q  <= 1'b0;
      gen_count_q <= '0;
    end else begin
      state_q    <= state_d;
      swap_ack_q <= (state_d == StSwap);
      if (start_run) gen_count_q <= '0;
      if (state_q == StSwap) begin
        cur_sel_q   <= ~cur_sel_q;
        gen_count_q <= gen_count_q + GEN_W'(1);
      end
    end
  end

`ifdef STABLE_DETECT_EN
  logic            stable_q;
  logic            diff_q;
  logic [ROWS-1:0] written_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q  <= 1'b0;
      diff_q    <= 1'b0;
      written_q <= '0;
    end else if (start_run) begin
      stable_q  <= 1'b0;
      diff_q    <= 1'b0;
      written_q <= '0;
    end else if (state_q == StSwap) begin
      stable_q  <= (&written_q) && !diff_q;
      diff_q    <= 1'b0;
      written_q <= '0;
    end else if (grid_wr) begin
      if (grid_row != bank_q[cur_sel_q][grid_addr]) diff_q <= 1'b1;
      written_q[grid_addr] <= 1'b1;
    end
  end

  assign stable = stable_q;
`else
  assign stable = 1'b0;
`endif

  assign rd_row    = rd_row_q;
  assign swap_ack  = swap_ack_q;
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_grid_generation_memory.sv
// Randomized bench for grid_generation_memory against a behavioural generation-memory model.
// Uses ROWS=12 to exercise out-of-range rows and GEN_W=4 to exercise counter wrap.
module tb_grid_generation_memory;
  localparam int unsigned COLS = 16;
  localparam int unsigned ROWS = 12;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned GEN_W = 4;

  logic clk = 1'b0;
  logic reset, load_run, init_we, grid_we, gen_done, swap_ack, stable;
  logic [ADDR_W-1:0] init_addr, rd_addr, grid_addr;
  logic [COLS-1:0]   init_row, grid_row, rd_row;
  logic [GEN_W-1:0]  gen_count;

  always #5 clk = ~clk;

  grid_generation_memory #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .GEN_W(GEN_W)
  ) dut (
    .clk(clk), .reset(reset), .load_run(load_run), .init_we(init_we), .init_addr(init_addr),
    .init_row(init_row), .rd_addr(rd_addr), .rd_row(rd_row), .grid_we(grid_we),
    .grid_addr(grid_addr), .grid_row(grid_row), .gen_done(gen_done), .swap_ack(swap_ack),
    .gen_count(gen_count), .stable(stable)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: two grids, which one is "current", a mode and the stable bookkeeping.
  localparam int ModeLoad = 0, ModeRun = 1, ModeSwap = 2;
  logic [COLS-1:0] grids [2][16];
  int  m_cur, m_mode, m_gen;
  bit  m_stable, m_diff, m_ack;
  bit  m_written [16];
  logic [COLS-1:0] m_rd;

  function automatic bit row_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < int'(ROWS);
  endfunction

  task automatic model_reset();
    foreach (grids[b, r]) grids[b][r] = '0;
    foreach (m_written[r]) m_written[r] = 0;
    m_cur = 0; m_mode = ModeLoad; m_gen = 0;
    m_stable = 0; m_diff = 0; m_ack = 0; m_rd = '0;
  endtask

  task automatic clear_stable_track();
    m_diff = 0;
    foreach (m_written[r]) m_written[r] = 0;
  endtask

  task automatic model_edge();
    int n_written;
    m_rd = row_ok(rd_addr) ? grids[m_cur][rd_addr] : '0;
    case (m_mode)
      ModeLoad: begin
        if (init_we && row_ok(init_addr)) grids[m_cur][init_addr] = init_row;
        if (load_run) begin
          m_mode = ModeRun; m_gen = 0; m_stable = 0;
          clear_stable_track();
        end
      end
      ModeRun: begin
        if (grid_we && row_ok(grid_addr)) begin
          if (grids[m_cur][grid_addr] != grid_row) m_diff = 1;
          m_written[grid_addr] = 1;
          grids[1 - m_cur][grid_addr] = grid_row;
        end
        if (!load_run) m_mode = ModeLoad;
        else if (gen_done) m_mode = ModeSwap;
      end
      default: begin
        n_written = 0;
        for (int r = 0; r < int'(ROWS); r++) n_written += m_written[r] ? 1 : 0;
        m_stable = (n_written == int'(ROWS)) && !m_diff;
        clear_stable_track();
        m_cur = 1 - m_cur;
        m_gen = (m_gen + 1) % (1 << GEN_W);
        m_mode = load_run ? ModeRun : ModeLoad;
      end
    endcase
    m_ack = (m_mode == ModeSwap);
  endtask

  task automatic check_outputs();
    bit exp_stable;
`ifdef STABLE_DETECT_EN
    exp_stable = m_stable;
`else
    exp_stable = 0;
`endif
    check_eq("rd_row", rd_row, m_rd);
    check_eq("swap_ack", swap_ack, m_ack);
    check_eq("gen_count", gen_count, m_gen);
    check_eq("stable", stable, exp_stable);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    init_we = 0; grid_we = 0; gen_done = 0;
  endtask

  // One generation copying the current grid, optionally flipping one row or skipping one row.
  task automatic stable_gen(input int change_row, input int omit_row);
    for (int r = 0; r < int'(ROWS); r++) begin
      grid_we = (r != omit_row);
      grid_addr = ADDR_W'(r);
      grid_row = grids[m_cur][r] ^ ((r == change_row) ? 16'h0001 : 16'h0000);
      step();
    end
    grid_we = 0; gen_done = 1; step();
    gen_done = 0; step(); step();
  endtask

  initial begin
    load_run = 0; init_addr = '0; rd_addr = '0; grid_addr = '0;
    init_row = '0; grid_row = '0; idle();
    reset = 1;
    #1 reset = 0;
    #1 model_reset();
    check_outputs();
    @(negedge clk) reset = 1;

    // Load rows with their address; rows 12..15 are out of range.
    for (int a = 0; a < 16; a++) begin
      init_we = 1; init_addr = ADDR_W'(a); init_row = 16'(a); rd_addr = ADDR_W'(a); step();
    end
    init_we = 0; load_run = 1; rd_addr = 4'd5; step(); step();

    // Run: next generation all ones; INIT_WE must be ignored.
    for (int a = 0; a < 16; a++) begin
      grid_we = 1; grid_addr = ADDR_W'(a); grid_row = 16'hFFFF;
      init_we = 1; init_addr = ADDR_W'(a); init_row = 16'h1234; rd_addr = ADDR_W'(a); step();
    end
    idle(); rd_addr = 4'd5; gen_done = 1; step();
    gen_done = 0; grid_we = 1; grid_addr = 4'd3; grid_row = 16'hAAAA; step();
    idle(); step(); step();

    // GRID_WE in load mode is ignored.
    load_run = 0; step();
    grid_we = 1; grid_addr = 4'd2; grid_row = 16'h5555; rd_addr = 4'd2; step();
    idle(); load_run = 1; step(); step();

    // Leaving run has priority over GEN_DONE.
    load_run = 0; gen_done = 1; step();
    gen_done = 0; load_run = 1; step(); step();

    // Still-life detection.
    stable_gen(-1, -1);
    stable_gen(-1, -1);
    stable_gen(4, -1);
    stable_gen(-1, -1);
    stable_gen(-1, 7);

    // Counter wrap across 17 swaps.
    repeat (17) begin
      gen_done = 1; step();
      gen_done = 0; step();
    end

    // Randomized traffic.
    repeat (3000) begin
      load_run  = ($urandom_range(0, 19) != 0);
      init_we   = $urandom_range(0, 1) == 1;
      init_addr = ADDR_W'($urandom_range(0, 15));
      init_row  = 16'($urandom);
      grid_we   = $urandom_range(0, 1) == 1;
      grid_addr = ADDR_W'($urandom_range(0, 15));
      grid_row  = ($urandom_range(0, 1) == 1 && row_ok(grid_addr)) ? grids[m_cur][grid_addr]
                                                                    : 16'($urandom);
      gen_done  = ($urandom_range(0, 6) == 0);
      rd_addr   = ADDR_W'($urandom_range(0, 15));
      step();
    end

    // Reset in the middle of run mode.
    idle(); load_run = 1; step(); step();
    #2 reset = 0;
    #1 model_reset();
    check_outputs();
    @(negedge clk) reset = 1;
    rd_addr = 4'd5; step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
